// File: rtl/ddr2_sdram_ex_lfsr_pkg.sv
// Shared types and defaults for the DDR2 example LFSR generator/checker.
package ddr2_sdram_ex_lfsr_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } chk_state_e;

  localparam logic [63:0] DEFAULT_POLY = 64'h1D;
  localparam logic [63:0] DEFAULT_SEED = 64'h20;

endpackage

// File: rtl/ddr2_sdram_ex_lfsr_gen_step.sv
// Combinational Galois LFSR advance: applies STEP single shifts in one cycle.
module ddr2_sdram_ex_lfsr_step #(
  parameter int          WIDTH = 8,
  parameter logic [63:0] POLY  = 64'h1D,
  parameter int          STEP  = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // The MSB rotates into bit 0 and is XORed into every tap above bit 0.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] fb;
    fb = c[WIDTH-1] ? {POLY[WIDTH-1:1], 1'b0} : '0;
    return {c[WIDTH-2:0], c[WIDTH-1]} ^ fb;
  endfunction

  always_comb begin
    nxt = cur;
    for (int s = 0; s < STEP; s++) begin
      nxt = shift1(nxt);
    end
  end

endmodule

// File: rtl/ddr2_sdram_ex_lfsr_gen.sv
// LFSR pattern generator with optional lock/error checker.
// Checker is compiled in only when DDR2_SDRAM_EX_LFSR_CHECK_EN is defined.
module ddr2_sdram_ex_lfsr_gen
  import ddr2_sdram_ex_lfsr_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [63:0] POLY      = DEFAULT_POLY,
  parameter logic [63:0] SEED      = DEFAULT_SEED,
  parameter int          STEP      = 1,
  parameter int          LOCK_CNT  = 4,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 pause,
  input  logic                 load,
  input  logic [WIDTH-1:0]     ldata,
  output logic [WIDTH-1:0]     data,
  input  logic                 chk_valid,
  input  logic [WIDTH-1:0]     chk_data,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("WIDTH must be in 4..64");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("SEED must be non-zero");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("STEP must be in 1..WIDTH");
  end
  if (LOCK_CNT < 1) begin : g_bad_lock
    $error("LOCK_CNT must be at least 1");
  end

  // ---------------- generator ----------------
  logic [WIDTH-1:0] gen_next;

  ddr2_sdram_ex_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .STEP  (STEP)
  ) u_gen_step (
    .cur (data),
    .nxt (gen_next)
  );

  // A zero load is replaced by SEED so the lock-up state is unreachable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= SEED_W;
    end else if (!enable) begin
      data <= SEED_W;
    end else if (load) begin
      data <= (ldata == '0) ? SEED_W : ldata;
    end else if (!pause) begin
      data <= gen_next;
    end
  end

`ifdef DDR2_SDRAM_EX_LFSR_CHECK_EN
  // ---------------- checker ----------------
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  chk_state_e           state, state_nxt;
  logic [CNT_W-1:0]     match_cnt, match_nxt;
  logic [CNT_W-1:0]     miss_cnt, miss_nxt;
  logic [WIDTH-1:0]     expected, exp_nxt;
  logic [WIDTH-1:0]     step_src, step_res;
  logic                 err_q, err_nxt;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_nxt;

  // HUNT re-seeds from the incoming word; LOCK free-runs on its own prediction.
  assign step_src = (state == HUNT) ? chk_data : expected;

  ddr2_sdram_ex_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .STEP  (STEP)
  ) u_chk_step (
    .cur (step_src),
    .nxt (step_res)
  );

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    exp_nxt   = expected;
    err_nxt   = 1'b0;
    cnt_nxt   = cnt_q;
    if (!enable) begin
      state_nxt = HUNT;
      match_nxt = '0;
      miss_nxt  = '0;
      exp_nxt   = SEED_W;
      cnt_nxt   = '0;
    end else begin
      if (chk_valid) begin
        exp_nxt = step_res;
        case (state)
          HUNT: begin
            if (chk_data == expected) begin
              if (match_cnt == CNT_W'(LOCK_CNT - 1)) begin
                state_nxt = LOCK;
                match_nxt = '0;
                miss_nxt  = '0;
              end else begin
                match_nxt = match_cnt + 1'b1;
              end
            end else begin
              match_nxt = '0;
            end
          end
          LOCK: begin
            if (chk_data != expected) begin
              err_nxt = 1'b1;
              if (!(&cnt_q)) cnt_nxt = cnt_q + 1'b1;
              if (miss_cnt == CNT_W'(LOCK_CNT - 1)) begin
                state_nxt = HUNT;
                miss_nxt  = '0;
                match_nxt = '0;
              end else begin
                miss_nxt = miss_cnt + 1'b1;
              end
            end else begin
              miss_nxt = '0;
            end
          end
          default: state_nxt = HUNT;
        endcase
      end
      if (clear_err) cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      expected  <= SEED_W;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      expected  <= exp_nxt;
      err_q     <= err_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  assign locked    = (state == LOCK);
  assign err       = err_q;
  assign err_count = cnt_q;
`else
  logic unused_chk;
  assign unused_chk = ^{chk_valid, chk_data, clear_err};
  assign locked     = 1'b0;
  assign err        = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_ddr2_sdram_ex_lfsr_gen.sv
// Randomized bench for ddr2_sdram_ex_lfsr_gen against a GF(2^8) reference model.
module tb_ddr2_sdram_ex_lfsr_gen;

`ifdef DDR2_SDRAM_EX_LFSR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  ldata = '0;
  logic        chk_valid = 1'b0;
  logic [7:0]  chk_data = '0;
  logic        clear_err = 1'b0;
  logic [7:0]  data, data2;
  logic        locked, err;
  logic [15:0] err_count;
  logic        unused_locked2, unused_err2;
  logic [15:0] unused_cnt2;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] m_data, m_data2, m_exp, ck_seq;
  bit         m_lock, m_err;
  int         m_mc, m_xc, m_cnt;

  always #5 clk = ~clk;

  ddr2_sdram_ex_lfsr_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pause(pause), .load(load),
    .ldata(ldata), .data(data), .chk_valid(chk_valid), .chk_data(chk_data),
    .clear_err(clear_err), .locked(locked), .err(err), .err_count(err_count)
  );

  ddr2_sdram_ex_lfsr_gen #(.STEP(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pause(pause), .load(load),
    .ldata(ldata), .data(data2), .chk_valid(chk_valid), .chk_data(chk_data),
    .clear_err(clear_err), .locked(unused_locked2), .err(unused_err2),
    .err_count(unused_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Multiplication by x modulo x^8+x^4+x^3+x^2+1, repeated n times.
  function automatic logic [7:0] ref_adv(input logic [7:0] x, input int n);
    int y;
    y = x;
    for (int i = 0; i < n; i++) begin
      y = y * 2;
      if (y >= 256) y = y ^ 'h11D;
    end
    return y[7:0];
  endfunction

  task automatic model_reset();
    m_data = 8'h20; m_data2 = 8'h20; m_exp = 8'h20;
    m_lock = 0; m_err = 0; m_mc = 0; m_xc = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit hit;
    if (!enable) begin
      m_data = 8'h20; m_data2 = 8'h20;
      m_lock = 0; m_mc = 0; m_xc = 0; m_cnt = 0; m_err = 0; m_exp = 8'h20;
    end else begin
      if (load) begin
        m_data  = (ldata == 0) ? 8'h20 : ldata;
        m_data2 = m_data;
      end else if (!pause) begin
        m_data  = ref_adv(m_data, 1);
        m_data2 = ref_adv(m_data2, 2);
      end
      m_err = 0;
      if (chk_valid) begin
        hit = (chk_data == m_exp);
        if (!m_lock) begin
          m_exp = ref_adv(chk_data, 1);
          if (hit) begin
            m_mc++;
            if (m_mc == 4) begin m_lock = 1; m_mc = 0; m_xc = 0; end
          end else m_mc = 0;
        end else begin
          m_exp = ref_adv(m_exp, 1);
          if (!hit) begin
            m_err = 1;
            if (m_cnt < 65535) m_cnt++;
            m_xc++;
            if (m_xc == 4) begin m_lock = 0; m_xc = 0; m_mc = 0; end
          end else m_xc = 0;
        end
      end
      if (clear_err) m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    check("data", data, m_data);
    check("data_step2", data2, m_data2);
    check("locked", locked, CHK ? m_lock : 1'b0);
    check("err", err, CHK ? m_err : 1'b0);
    check("err_count", err_count, CHK ? m_cnt : 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk); #1;
    compare_all();
    reset_n = 1'b1;
    enable = 1'b1;

    // basic sequences for STEP=1 and STEP=2
    cycle(); check("seq1_a", data, 8'h40); check("seq2_a", data2, 8'h80);
    cycle(); check("seq1_b", data, 8'h80); check("seq2_b", data2, 8'h3A);
    cycle(); check("seq1_c", data, 8'h1D);

    // zero load maps to SEED; load beats pause; pause holds
    load = 1; ldata = 8'h00; cycle(); check("load_zero", data, 8'h20);
    pause = 1; ldata = 8'h5A; cycle(); check("load_over_pause", data, 8'h5A);
    load = 0; cycle(); check("pause_hold", data, 8'h5A);
    pause = 0;

    // random generator controls, checker fed noise
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      load      = ($urandom_range(0, 7) == 0);
      pause     = ($urandom_range(0, 3) == 0);
      ldata     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      chk_valid = $urandom_range(0, 1);
      chk_data  = 8'($urandom_range(0, 255));
      clear_err = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // directed checker scenario fed from the generator's own sequence
    enable = 0; load = 0; pause = 0; chk_valid = 0; clear_err = 0;
    cycle();
    enable = 1; chk_valid = 1;
    for (int i = 0; i < 4; i++) begin chk_data = m_data; cycle(); end
`ifdef DDR2_SDRAM_EX_LFSR_CHECK_EN
    check("lock_after4", locked, 1'b1);
`endif
    chk_data = m_data ^ 8'h01; cycle();
`ifdef DDR2_SDRAM_EX_LFSR_CHECK_EN
    check("single_err", err, 1'b1);
    check("single_cnt", err_count, 16'd1);
    check("still_locked", locked, 1'b1);
`endif
    chk_data = m_data; cycle();
    clear_err = 1; chk_data = m_data; cycle();
    clear_err = 0;
    for (int i = 0; i < 4; i++) begin chk_data = m_data ^ 8'h80; cycle(); end
`ifdef DDR2_SDRAM_EX_LFSR_CHECK_EN
    check("burst_cnt", err_count, 16'd4);
    check("lost_lock", locked, 1'b0);
`endif
    for (int i = 0; i < 6; i++) begin chk_data = m_data; cycle(); end
    clear_err = 1; chk_data = m_data ^ 8'h10; cycle();
`ifdef DDR2_SDRAM_EX_LFSR_CHECK_EN
    check("clear_wins", err_count, 16'd0);
    check("clear_err_pulse", err, 1'b1);
`endif
    clear_err = 0;
    chk_data = m_data ^ 8'h04; cycle();
    chk_data = m_data; cycle();

    // asynchronous reset mid-lock, sampled between clock edges
    reset_n = 0;
    #2;
    model_reset();
    check("async_data", data, 8'h20);
    check("async_locked", locked, 1'b0);
    check("async_cnt", err_count, 16'd0);
    @(posedge clk); #1;
    reset_n = 1; chk_valid = 0;
    compare_all();

    // random checker traffic from an independent reference stream
    ck_seq = 8'h20;
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 63) != 0);
      load      = ($urandom_range(0, 7) == 0);
      pause     = ($urandom_range(0, 3) == 0);
      ldata     = 8'($urandom_range(0, 255));
      chk_valid = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 31) == 0);
      chk_data  = ck_seq;
      if ($urandom_range(0, 15) == 0 || (i >= 200 && i < 206))
        chk_data = ck_seq ^ 8'(1 << $urandom_range(0, 7));
      cycle();
      if (!enable) ck_seq = 8'h20;
      else if (chk_valid) ck_seq = ref_adv(ck_seq, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr2_sdram_ex_lfsr_gen.md
DDR2_SDRAM_EX_LFSR_GEN -- requirements
Module: ddr2_sdram_ex_lfsr_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the LFSR and data width (legal range 4..64).
REQ-002 The block SHALL have parameter POLY, default 'h1D, meaning the Galois feedback mask over WIDTH bits; bit i set means the MSB is XORed into bit i.
REQ-003 The block SHALL have parameter SEED, default 32, meaning the reset/restart value; zero is illegal and SHALL fail elaboration.
REQ-004 The block SHALL have parameter STEP, default 1, meaning the number of LFSR shifts per advance (1..WIDTH).
REQ-005 The block SHALL have parameter LOCK_CNT, default 4, meaning the consecutive matches to lock and the consecutive mismatches to lose lock.
REQ-006 The block SHALL have parameter ERR_CNT_W, default 16, meaning the error counter width.
REQ-007 The block SHALL have ports: clk, input, 1, sole clock; reset_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports: enable, input, 1, low restarts the block; pause, input, 1, holds the generator; load, input, 1, loads ldata.
REQ-009 The block SHALL have ports: ldata, input, WIDTH, load value; data, output, WIDTH, generator state.
REQ-010 The block SHALL have checker ports: chk_valid, input, 1; chk_data, input, WIDTH; clear_err, input, 1; locked, output, 1; err, output, 1; err_count, output, ERR_CNT_W.

Function
REQ-011 One shift SHALL be: next[0]=cur[W-1]; next[i]=cur[i-1]^(POLY[i]&cur[W-1]); an advance applies STEP shifts in one cycle.
REQ-012 Generator priority per cycle SHALL be: enable low -> data<=SEED; else load -> data<=ldata; else pause -> hold; else advance.
REQ-013 A load with ldata==0 SHALL load SEED instead, so the all-zero lock-up state is never entered.
REQ-014 data SHALL be the register directly (zero combinational latency after the clock edge).
REQ-015 The checker FSM SHALL have states HUNT and LOCK and operate only on cycles with chk_valid high.
REQ-016 In HUNT: expected<=advance(chk_data); a match of chk_data against the current expected increments match_cnt, a mismatch clears it; match_cnt reaching LOCK_CNT -> LOCK.
REQ-017 In LOCK: expected<=advance(expected), independent of chk_data; a mismatch pulses err for one cycle and increments err_count; LOCK_CNT consecutive mismatches -> HUNT.
REQ-018 err SHALL be registered, asserted the cycle after the offending chk_valid, and never asserted in HUNT.
REQ-019 err_count SHALL saturate at all-ones; clear_err synchronously zeroes it and wins over a simultaneous increment.
REQ-020 locked SHALL be high exactly while the FSM is in LOCK.
REQ-021 enable low SHALL force HUNT, clear match_cnt, miss_cnt, err and err_count.

Reset
REQ-022 reset_n low SHALL asynchronously set data=SEED, state=HUNT, locked=0, err=0, err_count=0, expected=SEED and clear all internal counters; reset mid-lock SHALL lose lock.

Configuration
REQ-023 With DDR2_SDRAM_EX_LFSR_CHECK_EN defined, the checker (REQ-015..021) SHALL be compiled in.
REQ-024 Without DDR2_SDRAM_EX_LFSR_CHECK_EN, checker ports SHALL remain, with locked, err and err_count tied to 0 and checker inputs ignored.

Structure
REQ-025 Package ddr2_sdram_ex_lfsr_pkg SHALL hold the FSM state typedef (HUNT, LOCK) and the default POLY/SEED constants.
REQ-026 Sub-module ddr2_sdram_ex_lfsr_step (combinational, parameters WIDTH/POLY/STEP) SHALL implement one advance and be instantiated for both generator and checker.

Verification
REQ-027 WIDTH=8, POLY='h1D, SEED='h20, STEP=1, enable high -> data sequence 20,40,80,1D.
REQ-028 STEP=2, same setup -> data sequence 20,80,3A.
REQ-029 load with ldata=0 -> data='h20 next cycle; load and pause together -> load wins.
REQ-030 Feed checker with generator output -> locked rises after 4 valid words; then corrupt one word -> err one cycle later, err_count=1, locked stays high.
REQ-031 In LOCK, 4 consecutive corrupt words -> err_count=4, locked falls; clear_err with a simultaneous error -> err_count=0.
REQ-032 Assert reset_n low mid-lock -> locked=0, err_count=0, data='h20 immediately, without waiting for a clock edge.
